sisc_ctrl_mc: RTL and testbench

SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

---
 rtl/sisc_pkg.sv | 60 ++++++
 rtl/sisc_ctrl_mc_if.sv | 41 ++++
 rtl/sisc_br_cond.sv | 34 +++
 rtl/sisc_ctrl_mc.sv | 194 +++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared encodings for the SISC multicycle controller
//
// Purpose : state encoding, opcode constants, addressing-mode and datapath
//           select encodings used by the controller, its branch-condition
//           helper and anything driving or checking them.
// Ports   : none (package).

package sisc_pkg;

  // START0 is encoded as all-zero so a flop bank that powers up cleared
  // lands in START0 before the first reset is ever applied.
  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } sisc_state_e;

  // instr[31:28]; 9..14 are undefined and behave as NOOP.
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_LOD  = 4'd2;
  localparam logic [3:0] OP_STR  = 4'd3;
  localparam logic [3:0] OP_SWP  = 4'd4;
  localparam logic [3:0] OP_BRA  = 4'd5;
  localparam logic [3:0] OP_BRR  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_BNR  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // mm value selecting the immediate operand for ALU_OP.
  localparam int AM_IMM = 8;

  // alu_op: bit1 = leave stat untouched, bit0 = use immediate operand.
  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_HOLD = 2'b10;
  localparam logic [1:0] ALU_ADDR = 2'b11;

  // wb_sel: register-file write data source.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_RB   = 2'b10;
  localparam logic [1:0] WB_ZERO = 2'b11;

  // Opcodes that go on to EXECUTE after DECODE (ALU_OP through BNR).
  function automatic logic op_executes(input logic [3:0] op);
    return (op >= OP_ALU) && (op <= OP_BNR);
  endfunction

  // PC-relative branch flavours select the relative target.
  function automatic logic op_is_rel_branch(input logic [3:0] op);
    return (op == OP_BRR) || (op == OP_BNR);
  endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// rtl/sisc_ctrl_mc_if.sv - instruction/status/memory bundle between controller and datapath
//
// Purpose : groups every non-clock, non-reset signal of the controller.
// Signals : opcode, mm, stat, mem_rdy          (datapath/memory -> controller)
//           mem_req, mem_we, ir_load, pc_write,
//           pc_sel, br_sel, rf_we, alu_op,
//           wb_sel, halted, fault              (controller -> datapath/memory)
// Modports: master = controller side, slave = datapath/memory side.

interface sisc_ctrl_mc_if #(
  parameter int STAT_W = 4
);
  logic [3:0]        opcode;
  logic [STAT_W-1:0] mm;
  logic [STAT_W-1:0] stat;
  logic              mem_rdy;

  logic              mem_req;
  logic              mem_we;
  logic              ir_load;
  logic              pc_write;
  logic              pc_sel;
  logic              br_sel;
  logic              rf_we;
  logic [1:0]        alu_op;
  logic [1:0]        wb_sel;
  logic              halted;
  logic              fault;

  modport master (
    input  opcode, mm, stat, mem_rdy,
    output mem_req, mem_we, ir_load, pc_write, pc_sel, br_sel,
           rf_we, alu_op, wb_sel, halted, fault
  );

  modport slave (
    output opcode, mm, stat, mem_rdy,
    input  mem_req, mem_we, ir_load, pc_write, pc_sel, br_sel,
           rf_we, alu_op, wb_sel, halted, fault
  );
endinterface

// File: rtl/sisc_br_cond.sv
// rtl/sisc_br_cond.sv - branch condition evaluation
//
// Purpose : decides whether a conditional branch is taken.
// Ports   : i_stat   status flags {C,N,V,Z}
//           i_mm     condition mask from instr[27:24]
//           i_opcode instr[31:28]
//           o_taken  1 = branch taken (0 for non-branch opcodes)

module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int STAT_W = 4
) (
  input  logic [STAT_W-1:0] i_stat,
  input  logic [STAT_W-1:0] i_mm,
  input  logic [3:0]        i_opcode,
  output logic              o_taken
);

  logic w_any;

  // BRA/BRR fire when any masked flag is set; BNE/BNR when none is.
  assign w_any = |(i_stat & i_mm);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BRA, OP_BRR: o_taken = w_any;
      OP_BNE, OP_BNR: o_taken = ~w_any;
      default:        o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// rtl/sisc_ctrl_mc.sv - multicycle SISC control unit
//
// Purpose : sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for the SISC
//           datapath, with a memory wait timeout that faults into HALT.
// Ports   : clk    system clock, rising edge
//           rst_f  asynchronous active-low reset (forces START1)
//           bus    sisc_ctrl_mc_if.master: opcode/mm/stat/mem_rdy in,
//                  strobes, selects, halted and fault out
// Params  : MEM_TMO  wait cycles on mem_rdy before fault (1..255)
//           STAT_W   width of stat and the mm condition mask

module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int MEM_TMO = 15,
  parameter int STAT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_f,
  sisc_ctrl_mc_if.master    bus
);

  sisc_state_e r_state;
  sisc_state_e w_state_nxt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nxt;
  logic        r_fault;
  logic        r_halted;
  logic        w_fault_set;
  logic        w_halt_set;
  logic        w_tmo;
  logic        w_taken;

  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_ir_load;
  logic        w_pc_write;
  logic        w_pc_sel;
  logic        w_br_sel;
  logic        w_rf_we;
  logic [1:0]  w_alu_op;
  logic [1:0]  w_wb_sel;

  sisc_br_cond #(
    .STAT_W (STAT_W)
  ) u_br_cond (
    .i_stat   (bus.stat),
    .i_mm     (bus.mm),
    .i_opcode (bus.opcode),
    .o_taken  (w_taken)
  );

  // The current cycle is the MEM_TMO-th consecutive one without mem_rdy.
  assign w_tmo = (r_wait == 8'(MEM_TMO - 1));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state  <= S_START1;
      r_wait   <= 8'd0;
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    // Counter clears whenever it is not explicitly advanced, which covers
    // every state exit as well as all non-waiting states.
    w_wait_nxt  = 8'd0;
    w_fault_set = 1'b0;
    w_halt_set  = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_load   = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_sel    = 1'b0;
    w_br_sel    = 1'b0;
    w_rf_we     = 1'b0;
    w_alu_op    = ALU_HOLD;
    w_wb_sel    = WB_ZERO;

    case (r_state)
      S_START0: w_state_nxt = S_START1;

      S_START1: w_state_nxt = S_FETCH;

      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) begin
          w_ir_load   = 1'b1;
          w_pc_write  = 1'b1;
          w_pc_sel    = 1'b0;
          w_state_nxt = S_DECODE;
        end else if (w_tmo) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_DECODE: begin
        if (bus.opcode == OP_HLT) begin
          w_halt_set  = 1'b1;
          w_state_nxt = S_HALT;
        end else if (op_executes(bus.opcode)) begin
          w_state_nxt = S_EXECUTE;
        end else begin
          // NOOP and the undefined opcodes simply fetch the next word.
          w_state_nxt = S_FETCH;
        end
      end

      S_EXECUTE: begin
        case (bus.opcode)
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            // pc_sel points at the target even when not taken; pc_write
            // alone decides whether the PC moves.
            w_pc_write  = w_taken;
            w_pc_sel    = 1'b1;
            w_br_sel    = op_is_rel_branch(bus.opcode);
            w_alu_op    = ALU_HOLD;
            w_state_nxt = S_FETCH;
          end
          OP_ALU: begin
            w_alu_op    = (bus.mm == STAT_W'(AM_IMM)) ? ALU_IMM : ALU_REG;
            w_state_nxt = S_WRITEBACK;
          end
          OP_LOD, OP_STR: begin
            w_alu_op    = ALU_ADDR;
            w_state_nxt = S_MEM;
          end
          OP_SWP: begin
            w_alu_op    = ALU_HOLD;
            w_state_nxt = S_WRITEBACK;
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (bus.opcode == OP_STR);
        if (bus.mem_rdy) begin
          w_state_nxt = (bus.opcode == OP_STR) ? S_FETCH : S_WRITEBACK;
        end else if (w_tmo) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_WRITEBACK: begin
        w_rf_we = 1'b1;
        case (bus.opcode)
          OP_ALU:  w_wb_sel = WB_ALU;
          OP_LOD:  w_wb_sel = WB_MEM;
          OP_SWP:  w_wb_sel = WB_RB;
          default: w_wb_sel = WB_ZERO;
        endcase
        w_state_nxt = S_FETCH;
      end

      S_HALT: w_state_nxt = S_HALT;

      default: w_state_nxt = S_START1;
    endcase
  end

  // Strobes are qualified with rst_f so they drop the instant reset is
  // asserted, independent of when the state flops settle.
  assign bus.mem_req  = w_mem_req  & rst_f;
  assign bus.mem_we   = w_mem_we   & rst_f;
  assign bus.ir_load  = w_ir_load  & rst_f;
  assign bus.pc_write = w_pc_write & rst_f;
  assign bus.rf_we    = w_rf_we    & rst_f;
  assign bus.pc_sel   = w_pc_sel;
  assign bus.br_sel   = w_br_sel;
  assign bus.alu_op   = w_alu_op;
  assign bus.wb_sel   = w_wb_sel;
  assign bus.halted   = r_halted;
  assign bus.fault    = r_fault;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb/tb_sisc_ctrl_mc.sv - self-checking bench for sisc_ctrl_mc

module tb_sisc_ctrl_mc;
  import sisc_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_f;

  sisc_ctrl_mc_if #(.STAT_W(4)) bus ();

  sisc_ctrl_mc #(
    .MEM_TMO (TMO),
    .STAT_W  (4)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference-model state: sticky flags and the instruction on the bus.
  logic       m_halted = 1'b0;
  logic       m_fault  = 1'b0;
  logic [3:0] cur_op   = 4'd0;
  logic [3:0] cur_mm   = 4'd0;
  logic [3:0] cur_st   = 4'd0;

  function automatic logic [12:0] obs();
    return {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_write, bus.pc_sel,
            bus.br_sel, bus.rf_we, bus.alu_op, bus.wb_sel, bus.halted, bus.fault};
  endfunction

  function automatic logic [12:0] ev(input logic req, input logic we, input logic irl,
                                     input logic pcw, input logic pcs, input logic brs,
                                     input logic rfw, input logic [1:0] alu,
                                     input logic [1:0] wb);
    return {req, we, irl, pcw, pcs, brs, rfw, alu, wb, m_halted, m_fault};
  endfunction

  function automatic logic [12:0] dflt();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input sisc_state_e est, input logic [12:0] evec);
    checks++;
    assert ({dut.r_state, obs()} === {est, evec}) else begin
      errors++;
      $error("FAIL %s: state=%0d out=%b expected state=%0d out=%b",
             tag, dut.r_state, obs(), est, evec);
    end
  endtask

  // One clock: apply inputs just after the edge, compare at the falling edge.
  task automatic cyc(input string tag, input logic rdy, input sisc_state_e est,
                     input logic [12:0] evec);
    @(posedge clk);
    #1;
    bus.mem_rdy = rdy;
    bus.opcode  = cur_op;
    bus.mm      = cur_mm;
    bus.stat    = cur_st;
    @(negedge clk);
    check(tag, est, evec);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_f = 1'b0;
    #1;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    check({tag, "_async"}, S_START1, dflt());
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    @(negedge clk);
    check({tag, "_start1"}, S_START1, dflt());
  endtask

  // Expected cycle sequence of one instruction, built from the instruction
  // rules: fd/md are the idle cycles before mem_rdy in FETCH/MEM, and
  // abort_mem > 0 stops the instruction after that many MEM wait cycles.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] mmv,
                           input logic [3:0] st, input int fd, input int md,
                           input int abort_mem);
    logic taken;
    logic is_str;
    cur_op = op;
    cur_mm = mmv;
    cur_st = st;
    for (int i = 0; i < fd; i++) begin
      cyc({tag, "_fwait"}, 1'b0, S_FETCH, ev(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b11));
      if (i == TMO - 1) begin
        m_fault = 1'b1;
        cyc({tag, "_ftmo"}, rnd(), S_HALT, dflt());
        return;
      end
    end
    cyc({tag, "_fetch"}, 1'b1, S_FETCH, ev(1, 0, 1, 1, 0, 0, 0, 2'b10, 2'b11));
    cyc({tag, "_decode"}, rnd(), S_DECODE, dflt());
    case (op)
      OP_HLT: begin
        m_halted = 1'b1;
        cyc({tag, "_halt"}, rnd(), S_HALT, dflt());
      end
      OP_ALU: begin
        cyc({tag, "_exec"}, rnd(), S_EXECUTE,
            ev(0, 0, 0, 0, 0, 0, 0, (mmv == 4'd8) ? 2'b01 : 2'b00, 2'b11));
        cyc({tag, "_wb"}, rnd(), S_WRITEBACK, ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00));
      end
      OP_SWP: begin
        cyc({tag, "_exec"}, rnd(), S_EXECUTE, dflt());
        cyc({tag, "_wb"}, rnd(), S_WRITEBACK, ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10));
      end
      OP_LOD, OP_STR: begin
        is_str = (op == OP_STR);
        cyc({tag, "_exec"}, rnd(), S_EXECUTE, ev(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11));
        for (int i = 0; i < md; i++) begin
          cyc({tag, "_mwait"}, 1'b0, S_MEM, ev(1, is_str, 0, 0, 0, 0, 0, 2'b10, 2'b11));
          if (abort_mem > 0 && i + 1 == abort_mem) return;
          if (i == TMO - 1) begin
            m_fault = 1'b1;
            cyc({tag, "_mtmo"}, rnd(), S_HALT, dflt());
            return;
          end
        end
        cyc({tag, "_mem"}, 1'b1, S_MEM, ev(1, is_str, 0, 0, 0, 0, 0, 2'b10, 2'b11));
        if (!is_str) begin
          cyc({tag, "_wb"}, rnd(), S_WRITEBACK, ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01));
        end
      end
      OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
        if (op == OP_BRA || op == OP_BRR) taken = ((st & mmv) != 4'd0);
        else                              taken = ((st & mmv) == 4'd0);
        cyc({tag, "_exec"}, rnd(), S_EXECUTE,
            ev(0, 0, 0, taken, 1, (op == OP_BRR || op == OP_BNR), 0, 2'b10, 2'b11));
      end
      default: ;
    endcase
  endtask

  // HALT must ignore every input change.
  task automatic hold_halt(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cur_op = 4'($urandom_range(0, 15));
      cur_mm = 4'($urandom_range(0, 15));
      cur_st = 4'($urandom_range(0, 15));
      cyc(tag, rnd(), S_HALT, dflt());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_f       = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.opcode  = 4'd0;
    bus.mm      = 4'd0;
    bus.stat    = 4'd0;
    @(negedge clk);
    do_reset("por");

    run_instr("add",   OP_ALU,  4'd0, 4'd5, 0, 0, 0);
    run_instr("adi",   OP_ALU,  4'd8, 4'd0, 1, 0, 0);
    run_instr("lod",   OP_LOD,  4'd0, 4'd0, 0, 3, 0);
    run_instr("bra",   OP_BRA,  4'd1, 4'd1, 0, 0, 0);
    run_instr("bnr",   OP_BNR,  4'd1, 4'd1, 0, 0, 0);
    run_instr("bne",   OP_BNE,  4'd2, 4'd1, 0, 0, 0);
    run_instr("brr",   OP_BRR,  4'd4, 4'd3, 2, 0, 0);
    run_instr("swp",   OP_SWP,  4'd0, 4'd0, 0, 0, 0);
    run_instr("str",   OP_STR,  4'd0, 4'd0, 0, 1, 0);
    run_instr("noop",  OP_NOOP, 4'd0, 4'd0, 0, 0, 0);
    run_instr("undef", 4'd12,   4'd0, 4'd0, 0, 0, 0);
    run_instr("lod14", OP_LOD,  4'd0, 4'd0, 0, TMO - 1, 0);
    run_instr("f14",   OP_ALU,  4'd8, 4'd0, TMO - 1, 0, 0);

    for (int k = 0; k < 60; k++) begin
      run_instr("rnd", 4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    run_instr("str_tmo", OP_STR, 4'd0, 4'd0, 0, 100, 0);
    hold_halt("tmo_hold", 4);
    do_reset("tmo_rst");

    run_instr("f_tmo", OP_ALU, 4'd0, 4'd0, 100, 0, 0);
    hold_halt("ftmo_hold", 2);
    do_reset("ftmo_rst");

    run_instr("hlt", OP_HLT, 4'd0, 4'd0, 0, 0, 0);
    hold_halt("hlt_hold", 20);
    do_reset("hlt_rst");
    run_instr("post_hlt", OP_ALU, 4'd0, 4'd0, 0, 0, 0);

    run_instr("str_rst", OP_STR, 4'd0, 4'd0, 0, 100, 5);
    do_reset("str_rst");
    run_instr("post_rst", OP_SWP, 4'd0, 4'd0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
